// File: rtl/l2_bank_sleep_ctrl.sv
// l2_bank_sleep_ctrl: per-bank adapter from one interleaved TCDM slave port to a
// single-port SRAM macro, with one-cycle response latency.
// Optional idle-driven retention FSM, compiled in when L2_BANK_SLEEP_EN is defined.
// Without L2_BANK_SLEEP_EN the macro never sleeps and every request is granted.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_ACTIVE | macro awake, requests granted, counting consecutive idle cycles
// ST_SLEEP  | macro in retention, grant withheld, waiting for a request
// ST_WAKE   | retention released, grant withheld until the macro has settled
module l2_bank_sleep_ctrl #(
  parameter int BANK_ADDR_WIDTH = 12,
  parameter int ADDR_LSB        = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int IDLE_CYCLES     = 64,
  parameter int WAKE_CYCLES     = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       tcdm_req_i,
  input  logic [31:0]                tcdm_add_i,
  input  logic                       tcdm_wen_i,
  input  logic [DATA_WIDTH-1:0]      tcdm_wdata_i,
  input  logic [3:0]                 tcdm_be_i,
  output logic                       tcdm_gnt_o,
  output logic [DATA_WIDTH-1:0]      tcdm_r_rdata_o,
  output logic                       tcdm_r_opc_o,
  output logic                       tcdm_r_valid_o,
  output logic                       mem_req_o,
  output logic                       mem_we_o,
  output logic [BANK_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]      mem_wdata_o,
  output logic [3:0]                 mem_be_o,
  input  logic [DATA_WIDTH-1:0]      mem_rdata_i,
  output logic                       mem_sleep_o
);

  // Reject configurations the datapath cannot support.
  if (DATA_WIDTH != 32 || IDLE_CYCLES < 1 || WAKE_CYCLES < 1 ||
      ADDR_LSB + BANK_ADDR_WIDTH > 32) begin : g_bad_cfg
    $error("l2_bank_sleep_ctrl: illegal parameter set");
  end

  logic active;
  logic mem_req;
  logic r_valid_d, r_valid_q;
  logic unused_add;

  // Only the bank word-index slice of the byte address reaches the macro.
  assign unused_add = ^tcdm_add_i;

  assign tcdm_gnt_o     = tcdm_req_i & active;
  assign mem_req        = tcdm_req_i & tcdm_gnt_o;
  assign mem_req_o      = mem_req;
  assign mem_we_o       = ~tcdm_wen_i;
  assign mem_addr_o     = tcdm_add_i[ADDR_LSB +: BANK_ADDR_WIDTH];
  assign mem_wdata_o    = tcdm_wdata_i;
  assign mem_be_o       = tcdm_be_i;
  assign tcdm_r_rdata_o = mem_rdata_i;
  assign tcdm_r_opc_o   = 1'b0;
  assign tcdm_r_valid_o = r_valid_q;

  // Response valid follows every SRAM access (read or write) by one cycle.
  always_comb r_valid_d = mem_req;

  // Response valid register; reset drops any in-flight response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_valid_q <= 1'b0;
    else         r_valid_q <= r_valid_d;
  end

`ifdef L2_BANK_SLEEP_EN
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {ST_ACTIVE, ST_SLEEP, ST_WAKE} state_e;

  state_e              state_q, state_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [WAKE_W-1:0]   wake_cnt_q, wake_cnt_d;
  logic                mem_sleep_q, mem_sleep_d;
  logic                idle;

  // A cycle with an outstanding response is busy even without a new request,
  // so a request arriving on the threshold cycle always wins over sleep entry.
  assign idle = ~tcdm_req_i & ~r_valid_q;

  // Next-state, idle/wake counters and registered retention request.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    unique case (state_q)
      ST_ACTIVE: begin
        if (!idle) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d    = ST_SLEEP;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      ST_SLEEP: begin
        if (tcdm_req_i) begin
          state_d    = ST_WAKE;
          wake_cnt_d = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (wake_cnt_q == '0) state_d    = ST_ACTIVE;
        else                  wake_cnt_d = wake_cnt_q - 1'b1;
      end
      default: state_d = ST_ACTIVE;
    endcase
    mem_sleep_d = (state_d == ST_SLEEP);
  end

  // Sleep FSM registers; reset wakes the macro immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_ACTIVE;
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      mem_sleep_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      mem_sleep_q <= mem_sleep_d;
    end
  end

  assign active      = (state_q == ST_ACTIVE);
  assign mem_sleep_o = mem_sleep_q;
`else
  assign active      = 1'b1;
  assign mem_sleep_o = 1'b0;
`endif

endmodule

// File: tb/tb_l2_bank_sleep_ctrl.sv
// tb_l2_bank_sleep_ctrl: randomized scoreboard bench for l2_bank_sleep_ctrl.
// Responds to both builds (L2_BANK_SLEEP_EN defined or not).
module tb_l2_bank_sleep_ctrl;
  localparam int BAW  = 12;
  localparam int LSB  = 2;
  localparam int IDLE = 8;
  localparam int WAKE = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b1;
  logic            tcdm_req_i = 1'b0;
  logic [31:0]     tcdm_add_i = '0;
  logic            tcdm_wen_i = 1'b1;
  logic [31:0]     tcdm_wdata_i = '0;
  logic [3:0]      tcdm_be_i = '0;
  logic            tcdm_gnt_o;
  logic [31:0]     tcdm_r_rdata_o;
  logic            tcdm_r_opc_o;
  logic            tcdm_r_valid_o;
  logic            mem_req_o;
  logic            mem_we_o;
  logic [BAW-1:0]  mem_addr_o;
  logic [31:0]     mem_wdata_o;
  logic [3:0]      mem_be_o;
  logic [31:0]     mem_rdata_i;
  logic            mem_sleep_o;

  always #5 clk_i = ~clk_i;

  l2_bank_sleep_ctrl #(
    .BANK_ADDR_WIDTH(BAW), .ADDR_LSB(LSB), .DATA_WIDTH(32),
    .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .tcdm_req_i(tcdm_req_i), .tcdm_add_i(tcdm_add_i), .tcdm_wen_i(tcdm_wen_i),
    .tcdm_wdata_i(tcdm_wdata_i), .tcdm_be_i(tcdm_be_i), .tcdm_gnt_o(tcdm_gnt_o),
    .tcdm_r_rdata_o(tcdm_r_rdata_o), .tcdm_r_opc_o(tcdm_r_opc_o),
    .tcdm_r_valid_o(tcdm_r_valid_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i), .mem_sleep_o(mem_sleep_o)
  );

  // SRAM macro model: one-cycle read latency, byte-masked writes.
  logic [31:0] sram [0:4095];
  logic [31:0] sram_rd;
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        sram_rd <= sram[mem_addr_o];
      end
    end
  end
  assign mem_rdata_i = sram_rd;

  // Scoreboard and reference state
  typedef struct { int due; bit rd; logic [31:0] data; } resp_t;
  resp_t       sb_q[$];
  resp_t       mon_e;
  logic [31:0] ref_mem [0:4095];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          last_gnt;

  // Reference sleep behaviour: run length of idle cycles, asleep flag, wake time left.
  bit m_asleep;
  int m_idle_run;
  int m_wake_left;
  bit m_valid;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_awake();
    return !m_asleep && m_wake_left == 0;
  endfunction

  function automatic void model_step(input bit req, input bit gnt);
    if (m_asleep) begin
      if (req) begin
        m_asleep    = 1'b0;
        m_wake_left = WAKE;
      end
    end else if (m_wake_left > 0) begin
      m_wake_left--;
    end else begin
      if (req || m_valid) m_idle_run = 0;
      else                m_idle_run++;
`ifdef L2_BANK_SLEEP_EN
      if (m_idle_run == IDLE) begin
        m_asleep   = 1'b1;
        m_idle_run = 0;
      end
`endif
    end
    m_valid = gnt;
  endfunction

  // Response monitor: pops one expectation per r_valid and checks timing and data.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (tcdm_r_valid_o) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL r_valid_unexpected: got r_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          chk("resp_cycle", cyc, mon_e.due);
          if (mon_e.rd) chk("rdata", tcdm_r_rdata_o, mon_e.data);
        end
      end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        n_checks++; n_errors++;
        $display("FAIL resp_missing: got r_valid=0 expected response due cycle %0d (cycle %0d)",
                 sb_q[0].due, cyc);
        void'(sb_q.pop_front());
      end
    end
  end

  // One bus cycle; entered and left 1 time unit after a rising edge.
  task automatic drive(input bit req, input logic [31:0] add, input bit wen,
                       input logic [31:0] wd, input logic [3:0] be);
    bit    eg;
    int    idx;
    resp_t r;
    tcdm_req_i = req; tcdm_add_i = add; tcdm_wen_i = wen;
    tcdm_wdata_i = wd; tcdm_be_i = be;
    eg = req && m_awake();
    @(negedge clk_i);
    chk("gnt", tcdm_gnt_o, eg);
    chk("mem_req", mem_req_o, eg);
    chk("mem_sleep", mem_sleep_o, m_asleep);
    chk("r_opc", tcdm_r_opc_o, 0);
    if (eg) begin
      idx = int'((add >> LSB) & 32'hFFF);
      chk("mem_addr", mem_addr_o, idx);
      chk("mem_we", mem_we_o, !wen);
      chk("mem_wdata", mem_wdata_o, wd);
      chk("mem_be", mem_be_o, be);
      r.due = cyc + 1;
      r.rd  = wen;
      r.data = ref_mem[idx];
      sb_q.push_back(r);
      if (!wen)
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
    end
    model_step(req, eg);
    last_gnt = eg;
    @(posedge clk_i); #1;
  endtask

  task automatic access(input logic [31:0] add, input bit wen,
                        input logic [31:0] wd, input logic [3:0] be);
    int n = 0;
    do begin
      drive(1'b1, add, wen, wd, be);
      n++;
    end while (!last_gnt && n < 20);
    if (!last_gnt) begin
      n_checks++; n_errors++;
      $display("FAIL grant_timeout: got no grant expected grant within 20 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom, 1'(($urandom)), $urandom, 4'($urandom));
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; tcdm_req_i = 1'b0; #1;
    chk("rst_r_valid", tcdm_r_valid_o, 0);
    chk("rst_mem_sleep", mem_sleep_o, 0);
    tcdm_req_i = 1'b1; #1;
    chk("rst_gnt", tcdm_gnt_o, 1);
    chk("rst_mem_req", mem_req_o, 1);
    chk("rst_r_opc", tcdm_r_opc_o, 0);
    tcdm_req_i = 1'b0;
    sb_q.delete();
    m_asleep = 1'b0; m_wake_left = 0; m_idle_run = 0; m_valid = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[LSB +: BAW] = 12'($urandom_range(0, 15));
    return a;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
    @(posedge clk_i); #1;
    do_reset();

    // Back-to-back write then read of the same word
    access(32'h1C00_0010, 1'b0, 32'hDEAD_BEEF, 4'hF);
    access(32'h1C00_0010, 1'b1, 32'h0, 4'hF);

    // Idle into sleep, then wake with a read
    idle(IDLE + 3);
    access(32'h1C00_0010, 1'b1, 32'h0, 4'hF);

    // Request on the threshold cycle: one response cycle, then IDLE-1 idle cycles
    idle(1);
    idle(IDLE - 1);
    access(rand_addr(), 1'b0, $urandom, 4'hF);
    idle(IDLE + 2);

    // Reset while asleep, then reset mid-wake
    do_reset();
    access(rand_addr(), 1'b1, 32'h0, 4'hF);
    idle(IDLE + 2);
    drive(1'b1, 32'h1C00_0020, 1'b1, 32'h0, 4'hF);
    drive(1'b1, 32'h1C00_0020, 1'b1, 32'h0, 4'hF);
    do_reset();
    access(32'h1C00_0020, 1'b1, 32'h0, 4'hF);

    // Long idle stretch
    idle(1000);
    access(rand_addr(), 1'b1, 32'h0, 4'hF);

    // Randomized traffic mixed with idle bursts
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7)
        access(rand_addr(), 1'($urandom), $urandom, 4'($urandom));
      else
        idle($urandom_range(1, IDLE + 3));
    end

    idle(3);
    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
